systolic_feeder_3x3: RTL and testbench

SYSTOLIC_FEEDER_3X3 -- requirements
Module: systolic_feeder_3x3

---
 rtl/systolic_feeder_3x3.sv | 86 ++++++++
 tb/tb_systolic_feeder_3x3.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_3x3.sv
// systolic_feeder_3x3: skews 3x3 A/B buffers into a systolic array edge (optional FEEDER_PERF_CNT_EN adds perf_jobs)
module systolic_feeder_3x3 #(
  parameter int DATA_W = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [1:0]        ld_idx,
  input  logic [3*DATA_W-1:0] ld_data,
  input  logic              start,
  output logic              busy,
  output logic              arr_clear,
  output logic [3*DATA_W-1:0] left_data,
  output logic [3*DATA_W-1:0] up_data,
`ifdef FEEDER_PERF_CNT_EN
  output logic [7:0]        perf_jobs,
`endif
  output logic              done
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [DATA_W-1:0] a [3][3];
  logic [DATA_W-1:0] b [3][3];
  logic [3*DATA_W-1:0] left_n, up_n;
  always_comb begin
    state_n = state == IDLE  ? (start ? CLEAR : IDLE) :
              state == CLEAR ? FEED :
              state == FEED  ? (cnt == 4'd4 ? DRAIN : FEED) :
              state == DRAIN ? (cnt == 4'(DRAIN_CYCLES - 1) ? DONE : DRAIN) : IDLE;
    cnt_n = state_n != state ? 4'd0 : cnt + 4'd1;
  end
  always_comb begin
    left_n = '0;
    up_n = '0;
    for (int i = 0; i < 3; i++) begin
      if (state_n == FEED && cnt_n >= 4'(i) && cnt_n - 4'(i) <= 4'd2) begin
        left_n[i*DATA_W +: DATA_W] = a[2'(i)][2'(cnt_n - 4'(i))];
        up_n[i*DATA_W +: DATA_W] = b[2'(cnt_n - 4'(i))][2'(i)];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++) begin
          a[i][k] <= '0;
          b[i][k] <= '0;
        end
    end else if (ld_valid && ld_ready && ld_idx != 2'd3) begin
      for (int k = 0; k < 3; k++)
        if (ld_sel) b[2'(k)][ld_idx] <= ld_data[k*DATA_W +: DATA_W];
        else a[ld_idx][2'(k)] <= ld_data[k*DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ld_ready <= 1'b1;
      busy <= 1'b0;
      arr_clear <= 1'b0;
      done <= 1'b0;
      left_data <= '0;
      up_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ld_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      arr_clear <= state_n == CLEAR;
      done <= state_n == DONE;
      left_data <= left_n;
      up_data <= up_n;
    end
  end
`ifdef FEEDER_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) perf_jobs <= '0;
    else if (state_n == DONE) perf_jobs <= perf_jobs + 8'd1;
  end
`endif
endmodule

// File: tb/tb_systolic_feeder_3x3.sv
// tb_systolic_feeder_3x3: directed self-checking bench for systolic_feeder_3x3
module tb_systolic_feeder_3x3;
  logic clk, reset, ld_valid, ld_ready, ld_sel, start, busy, arr_clear, done;
  logic [1:0] ld_idx;
  logic [11:0] ld_data, left_data, up_data;
`ifdef FEEDER_PERF_CNT_EN
  logic [7:0] perf_jobs;
`endif
  int total = 0, bad = 0, c, ndone, donec;
  logic clr;
  logic [11:0] gl [5], gu [5], el [5], eu [5];
  systolic_feeder_3x3 dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_idx(ld_idx), .ld_data(ld_data), .start(start), .busy(busy), .arr_clear(arr_clear),
    .left_data(left_data), .up_data(up_data),
`ifdef FEEDER_PERF_CNT_EN
    .perf_jobs(perf_jobs),
`endif
    .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [11:0] pk(input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2);
    return {e2, e1, e0};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic load(input logic sel, input logic [1:0] idx, input logic [11:0] d);
    ld_valid = 1'b1;
    ld_sel = sel;
    ld_idx = idx;
    ld_data = d;
    tick;
    ld_valid = 1'b0;
  endtask
  task automatic run_job(input bit hold, input bit inj);
    start = 1'b1;
    tick;
    start = hold;
    c = 1;
    ndone = 0;
    donec = 0;
    clr = arr_clear;
    while (c < 40) begin
      ld_valid = inj && c == 7;
      ld_sel = 1'b0;
      ld_idx = 2'd0;
      ld_data = 12'hfff;
      if (inj && c == 7) chk("ready_in_drain", ld_ready, 0);
      tick;
      c++;
      if (c == 6) start = 1'b0;
      if (c >= 2 && c <= 6) begin
        gl[c-2] = left_data;
        gu[c-2] = up_data;
      end
      if (done) begin
        ndone++;
        donec = c;
      end
      if (!busy) break;
    end
    ld_valid = 1'b0;
    start = 1'b0;
  endtask
  task automatic chk_job(input string tag);
    chk({tag, "_clear"}, clr, 1);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_donec"}, donec, 11);
  endtask
  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_idx = 2'd0; ld_data = '0; start = 1'b0;
    el[0] = pk(1,0,0); el[1] = pk(2,4,0); el[2] = pk(3,5,7); el[3] = pk(0,6,8); el[4] = pk(0,0,9);
    eu[0] = pk(1,0,0); eu[1] = pk(0,0,0); eu[2] = pk(0,1,0); eu[3] = pk(0,0,0); eu[4] = pk(0,0,1);
    tick;
    tick;
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", ld_ready, 1);
    chk("rst_clear", arr_clear, 0);
    chk("rst_done", done, 0);
    chk("rst_left", left_data, 0);
    chk("rst_up", up_data, 0);
    load(0, 0, pk(1,2,3));
    load(0, 1, pk(4,5,6));
    load(0, 2, pk(7,8,9));
    load(1, 0, pk(1,0,0));
    load(1, 1, pk(0,1,0));
    load(1, 2, pk(0,0,1));
    chk("ready_idle", ld_ready, 1);
    run_job(0, 0);
    chk_job("job1");
    for (int t = 0; t < 5; t++) begin
      chk($sformatf("job1_left_t%0d", t), gl[t], el[t]);
      chk($sformatf("job1_up_t%0d", t), gu[t], eu[t]);
    end
    chk("job1_idle_ready", ld_ready, 1);
    chk("job1_idle_left", left_data, 0);
    run_job(1, 1);
    chk_job("ignore_start");
    run_job(0, 0);
    chk_job("replay");
    for (int t = 0; t < 5; t++) chk($sformatf("replay_left_t%0d", t), gl[t], el[t]);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_idx = 2'd3; ld_data = 12'hfff;
    chk("idx3_ready_a", ld_ready, 1);
    tick;
    ld_sel = 1'b1;
    chk("idx3_ready_b", ld_ready, 1);
    tick;
    ld_valid = 1'b0;
    run_job(0, 0);
    chk_job("idx3");
    for (int t = 0; t < 5; t++) begin
      chk($sformatf("idx3_left_t%0d", t), gl[t], el[t]);
      chk($sformatf("idx3_up_t%0d", t), gu[t], eu[t]);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    chk("mid_left_t2", left_data, el[2]);
    reset = 1'b1;
    start = 1'b1;
    ld_valid = 1'b1; ld_sel = 1'b0; ld_idx = 2'd1; ld_data = 12'hfff;
    tick;
    reset = 1'b0; start = 1'b0; ld_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_left", left_data, 0);
    chk("midrst_up", up_data, 0);
    chk("midrst_ready", ld_ready, 1);
    chk("midrst_clear", arr_clear, 0);
    run_job(0, 0);
    chk_job("zero");
    for (int t = 0; t < 5; t++) begin
      chk($sformatf("zero_left_t%0d", t), gl[t], 0);
      chk($sformatf("zero_up_t%0d", t), gu[t], 0);
    end
    ld_valid = 1'b1; ld_sel = 1'b0; ld_idx = 2'd0; ld_data = pk(1,2,3); start = 1'b1;
    tick;
    ld_valid = 1'b0; start = 1'b0;
    chk("same_cycle_clear", arr_clear, 1);
    tick;
    chk("same_cycle_left_t0", left_data, pk(1,0,0));
    tick;
    chk("same_cycle_left_t1", left_data, pk(2,0,0));
    c = 0;
    while (busy && c < 40) begin
      tick;
      c++;
    end
    chk("same_cycle_end", busy, 0);
`ifdef FEEDER_PERF_CNT_EN
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("perf_rst", perf_jobs, 0);
    for (int j = 0; j < 257; j++) run_job(0, 0);
    chk("perf_wrap", perf_jobs, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
